// File: rtl/window_linebuf.sv
// Vertical window line buffer: keeps the previous KH-1 padded rows in rotating line memories
// and emits, per streamed pixel, the KH-tall column of taps (oldest row in the LSBs).
module window_linebuf #(
  parameter int unsigned SZI     = 8,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned MAX_W   = 256,
  parameter int unsigned MAX_K   = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           cfg_valid,
  input  logic [$clog2(MAX_W)-1:0]       cfg_size_w,
  input  logic [$clog2(MAX_K+1)-1:0]     cfg_kh,
  input  logic [SZI*A_WIDTH-1:0]         d_value,
  input  logic                           d_valid,
  input  logic                           d_last_w,
  input  logic                           d_last_elm,
  output logic                           d_ready,
  output logic [MAX_K*SZI*A_WIDTH-1:0]   q_value,
  output logic                           q_valid,
  input  logic                           q_ready,
  output logic                           q_first_col,
  output logic                           q_last_w,
  output logic                           q_last_elm,
  output logic                           err
);

  localparam int unsigned DW = SZI * A_WIDTH;
  localparam int unsigned QW = MAX_K * DW;
  localparam int unsigned CW = $clog2(MAX_W);
  localparam int unsigned KW = $clog2(MAX_K + 1);
  localparam int unsigned NL = MAX_K - 1;
  localparam int unsigned SW = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

  state_t          state_q;
  logic [CW-1:0]   col_q, wlast_q;
  logic [KW-1:0]   kh_q, row_q;
  logic [SW-1:0]   wr_sel_q;
  logic            last_seen_q, err_q;
  logic [QW-1:0]   q_value_q;
  logic            q_valid_q, q_first_col_q, q_last_w_q, q_last_elm_q;
  logic [DW-1:0]   mem [NL][MAX_W];

  logic            d_acc, q_acc, col_end;
  logic [KW-1:0]   kh_m1, kh_m2;
  logic [QW-1:0]   taps_d;

  assign d_ready = (state_q == S_FILL) |
                   ((state_q == S_STREAM) & (!q_valid_q | q_ready) & !last_seen_q);
  assign d_acc   = d_valid & d_ready;
  assign q_acc   = q_valid_q & q_ready;
  assign col_end = (col_q == wlast_q);
  assign kh_m1   = kh_q - KW'(1);
  assign kh_m2   = kh_q - KW'(2);

  // Memory wr_sel holds the oldest stored row; later rows follow in rotation order.
  always_comb begin
    int unsigned sum;
    sum    = 0;
    taps_d = '0;
    for (int unsigned i = 0; i < MAX_K; i++) begin
      if (i + 1 < 32'(kh_q)) begin
        sum = 32'(wr_sel_q) + i;
        if (sum >= 32'(kh_m1)) sum = sum - 32'(kh_m1);
        taps_d[i*DW +: DW] = mem[sum[SW-1:0]][col_q];
      end else if (i + 1 == 32'(kh_q)) begin
        taps_d[i*DW +: DW] = d_value;
      end
    end
  end

  // Write lands after the same-edge read, so the tap sees the row being replaced.
  always_ff @(posedge clk) begin
    if (d_acc) mem[wr_sel_q][col_q] <= d_value;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      wlast_q       <= '0;
      kh_q          <= '0;
      row_q         <= '0;
      wr_sel_q      <= '0;
      last_seen_q   <= 1'b0;
      err_q         <= 1'b0;
      q_value_q     <= '0;
      q_valid_q     <= 1'b0;
      q_first_col_q <= 1'b0;
      q_last_w_q    <= 1'b0;
      q_last_elm_q  <= 1'b0;
    end else begin
      if (q_acc) q_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            if (cfg_size_w == '0 || cfg_kh == '0 || 32'(cfg_kh) > MAX_K) begin
              err_q <= 1'b1;
            end else begin
              err_q       <= 1'b0;
              wlast_q     <= cfg_size_w - CW'(1);
              kh_q        <= cfg_kh;
              col_q       <= '0;
              row_q       <= '0;
              wr_sel_q    <= '0;
              last_seen_q <= 1'b0;
              state_q     <= (cfg_kh == KW'(1)) ? S_STREAM : S_FILL;
            end
          end
        end
        S_FILL, S_STREAM: begin
          if (cfg_valid) err_q <= 1'b1;
          if (d_acc) begin
            if (d_last_w != col_end) err_q <= 1'b1;
            if (col_end) begin
              col_q <= '0;
              if (row_q != kh_m1) row_q <= row_q + KW'(1);
              if (kh_q < KW'(2) || wr_sel_q == kh_m2[SW-1:0]) wr_sel_q <= '0;
              else                                             wr_sel_q <= wr_sel_q + SW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
          if (state_q == S_FILL) begin
            if (d_acc && d_last_elm) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (d_acc && col_end && row_q == kh_m2) begin
              state_q <= S_STREAM;
            end
          end else begin
            if (d_acc) begin
              q_value_q     <= taps_d;
              q_valid_q     <= 1'b1;
              q_first_col_q <= (col_q == '0);
              q_last_w_q    <= col_end;
              q_last_elm_q  <= d_last_elm;
              if (d_last_elm) last_seen_q <= 1'b1;
            end
            if (q_acc && q_last_elm_q) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign q_value     = q_value_q;
  assign q_valid     = q_valid_q;
  assign q_first_col = q_first_col_q;
  assign q_last_w    = q_last_w_q;
  assign q_last_elm  = q_last_elm_q;
  assign err         = err_q;

endmodule

// File: tb/tb_window_linebuf.sv
// Bench for window_linebuf: table of layer runs checked against a frame-array reference model,
// plus hand-written reset, bad-config and mid-layer reset sequences.
module tb_window_linebuf;

  localparam int unsigned QW = 192;

  logic         clk = 1'b0;
  logic         resetn;
  logic         cfg_valid;
  logic [7:0]   cfg_size_w;
  logic [1:0]   cfg_kh;
  logic [63:0]  d_value;
  logic         d_valid, d_last_w, d_last_elm, d_ready;
  logic [QW-1:0] q_value;
  logic         q_valid, q_ready, q_first_col, q_last_w, q_last_elm, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] frame [8][256];

  typedef struct {
    int unsigned w, kh, rows;
    int unsigned rdy_mode;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
    bit          rnd;        // random data and input gaps
    int          bad_col;    // extra d_last_w in row 0 at this column (-1 none)
    bit          glitch;     // cfg_valid pulse mid-layer
    int unsigned abort_at;   // stop after this many accepted pixels (0 none)
    bit          chk_ends;
    logic [23:0] exp_first, exp_last;
    int unsigned exp_out;
    bit          exp_err;
  } layer_t;

  window_linebuf #(.SZI(8), .A_WIDTH(8), .MAX_W(256), .MAX_K(3)) dut (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_size_w(cfg_size_w),
    .cfg_kh(cfg_kh), .d_value(d_value), .d_valid(d_valid), .d_last_w(d_last_w),
    .d_last_elm(d_last_elm), .d_ready(d_ready), .q_value(q_value), .q_valid(q_valid),
    .q_ready(q_ready), .q_first_col(q_first_col), .q_last_w(q_last_w),
    .q_last_elm(q_last_elm), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] low_bytes(input logic [QW-1:0] v);
    return {v[128 +: 8], v[64 +: 8], v[0 +: 8]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_d_ready"}, 200'(d_ready), 200'(0));
    chk({tag, "_q_valid"}, 200'(q_valid), 200'(0));
    chk({tag, "_q_value"}, 200'(q_value), 200'(0));
    chk({tag, "_q_flags"}, 200'({q_first_col, q_last_w, q_last_elm}), 200'(0));
    chk({tag, "_err"}, 200'(err), 200'(0));
  endtask

  task automatic run_layer(input layer_t t);
    int unsigned total, p, n_out, cyc, budget;
    int r, c;
    bit glitched, prev_stall, prev_acc, viol_prev;
    logic [QW-1:0] prev_val, got_first, got_last, tv;
    logic [194:0] expq[$];
    logic [194:0] e;
    logic [3:0] pat;
    total = t.rows * t.w;
    p = 0; n_out = 0; cyc = 0;
    budget = 40 * total + 200;
    glitched = 0; prev_stall = 0; prev_acc = 0; viol_prev = 0;
    prev_val = '0; got_first = '0; got_last = '0;
    pat = 4'b1001;
    for (int rr = 0; rr < int'(t.rows); rr++)
      for (int cc = 0; cc < int'(t.w); cc++)
        frame[rr][cc] = t.rnd ? {$urandom, $urandom} : 64'(rr * 16 + cc);

    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_size_w = 8'(t.w); cfg_kh = 2'(t.kh);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("err_clear_on_cfg", 200'(err), 200'(0));

    while (cyc < budget && (p < total || n_out < t.exp_out)) begin
      if (t.abort_at != 0 && p >= t.abort_at) break;
      @(posedge clk); #1;
      r = int'(p / t.w);
      c = int'(p % t.w);
      cfg_valid = t.glitch && !glitched && p == 2;
      if (cfg_valid) begin
        glitched = 1; cfg_size_w = 8'd7; cfg_kh = 2'd2;
      end
      d_valid    = (p < total) && (t.rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      d_value    = frame[r % 8][c % 256];
      d_last_w   = (c == int'(t.w) - 1) || (r == 0 && c == t.bad_col);
      d_last_elm = (p == total - 1);
      case (t.rdy_mode)
        0:       q_ready = 1'b1;
        1:       q_ready = pat[cyc % 4];
        default: q_ready = ($urandom_range(0, 2) != 0);
      endcase
      cyc++;
      @(negedge clk);
      if (prev_stall) chk("hold_while_stalled", 200'({q_valid, q_value}), 200'({1'b1, prev_val}));
      if (prev_acc)   chk("latency_one_cycle", 200'(q_valid), 200'(1));
      if (viol_prev)  chk("err_on_last_w_mismatch", 200'(err), 200'(1));
      if (q_valid && !q_ready) chk("d_ready_low_when_stalled", 200'(d_ready), 200'(0));
      if (q_valid && q_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", 200'(1), 200'(0));
        end else begin
          e = expq.pop_front();
          chk("output_taps_flags", 200'({q_last_elm, q_last_w, q_first_col, q_value}), 200'(e));
        end
        if (n_out == 0) got_first = q_value;
        got_last = q_value;
        n_out++;
      end
      prev_stall = q_valid && !q_ready;
      prev_val   = q_value;
      prev_acc   = 0;
      viol_prev  = 0;
      if (d_valid && d_ready) begin
        viol_prev = (d_last_w != (c == int'(t.w) - 1));
        if (r >= int'(t.kh) - 1) begin
          tv = '0;
          for (int i = 0; i < int'(t.kh); i++)
            tv[i*64 +: 64] = frame[r - int'(t.kh) + 1 + i][c];
          expq.push_back({(p == total - 1), (c == int'(t.w) - 1), (c == 0), tv});
          prev_acc = 1;
        end
        p++;
      end
    end

    if (t.abort_at != 0) begin
      d_valid = 1'b0;
      return;
    end
    if (cyc >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL layer_timeout: got %0d outputs after %0d cycles, required %0d", n_out, cyc, t.exp_out);
    end

    @(posedge clk); #1;
    d_valid = 1'b0; q_ready = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b1;
    @(negedge clk);
    chk("idle_d_ready", 200'(d_ready), 200'(0));
    chk("idle_q_valid", 200'(q_valid), 200'(0));
    chk("err_final", 200'(err), 200'(t.exp_err));
    chk("output_count", 200'(n_out), 200'(t.exp_out));
    if (t.chk_ends) begin
      chk("first_taps", 200'(low_bytes(got_first)), 200'(t.exp_first));
      chk("last_taps", 200'(low_bytes(got_last)), 200'(t.exp_last));
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  initial begin
    layer_t tab[14];
    layer_t lt;
    int unsigned w, kh, rows;

    tab[0]  = '{4, 3, 5, 0, 1'b0, -1, 1'b0, 0, 1'b1, 24'h201000, 24'h433323, 12, 1'b0};
    tab[1]  = '{3, 1, 2, 0, 1'b0, -1, 1'b0, 0, 1'b1, 24'h000000, 24'h000012, 6, 1'b0};
    tab[2]  = '{4, 3, 5, 1, 1'b0, -1, 1'b0, 0, 1'b1, 24'h201000, 24'h433323, 12, 1'b0};
    tab[3]  = '{4, 3, 5, 0, 1'b0,  2, 1'b0, 0, 1'b1, 24'h201000, 24'h433323, 12, 1'b1};
    tab[4]  = '{4, 3, 2, 0, 1'b0, -1, 1'b0, 0, 1'b0, 24'h0, 24'h0, 0, 1'b1};
    tab[5]  = '{3, 2, 4, 0, 1'b0, -1, 1'b1, 0, 1'b1, 24'h001000, 24'h003222, 9, 1'b1};
    tab[6]  = '{1, 3, 4, 0, 1'b0, -1, 1'b0, 0, 1'b1, 24'h201000, 24'h302010, 2, 1'b0};
    tab[7]  = '{255, 3, 3, 2, 1'b1, -1, 1'b0, 0, 1'b0, 24'h0, 24'h0, 255, 1'b0};
    for (int i = 8; i < 14; i++) begin
      w    = $urandom_range(1, 8);
      kh   = $urandom_range(1, 3);
      rows = $urandom_range(kh, kh + 3);
      tab[i] = '{w, kh, rows, 2, 1'b1, -1, 1'b0, 0, 1'b0, 24'h0, 24'h0, (rows - kh + 1) * w, 1'b0};
    end

    resetn = 1'b0; cfg_valid = 1'b0; cfg_size_w = '0; cfg_kh = '0;
    d_value = '0; d_valid = 1'b0; d_last_w = 1'b0; d_last_elm = 1'b0; q_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    resetn = 1'b1; d_valid = 1'b1;
    @(negedge clk);
    chk("idle_ignores_d_valid", 200'(d_ready), 200'(0));

    @(posedge clk); #1;
    d_valid = 1'b0; cfg_valid = 1'b1; cfg_size_w = 8'd0; cfg_kh = 2'd3;
    @(posedge clk); #1;
    cfg_valid = 1'b0; d_valid = 1'b1;
    @(negedge clk);
    chk("err_cfg_width_zero", 200'(err), 200'(1));
    chk("bad_cfg_stays_idle", 200'(d_ready), 200'(0));
    @(posedge clk); #1;
    d_valid = 1'b0; cfg_valid = 1'b1; cfg_size_w = 8'd4; cfg_kh = 2'd0;
    @(posedge clk); #1;
    cfg_valid = 1'b0; d_valid = 1'b1;
    @(negedge clk);
    chk("kh_zero_stays_idle", 200'(d_ready), 200'(0));
    @(posedge clk); #1;
    d_valid = 1'b0;

    for (int i = 0; i < 14; i++) run_layer(tab[i]);

    lt = '{4, 3, 5, 0, 1'b0, -1, 1'b0, 13, 1'b0, 24'h0, 24'h0, 0, 1'b0};
    run_layer(lt);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midlayer_reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    lt = '{2, 2, 3, 0, 1'b0, -1, 1'b0, 0, 1'b1, 24'h001000, 24'h002111, 4, 1'b0};
    run_layer(lt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
